// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Queued load/store front end for a data cache with a 1-cycle
//               synchronous read port and a tagged load-response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             dc_rd_en,
    output logic [15:0]      dc_rd_dest,
    output logic             dc_wr_en,
    output logic [15:0]      dc_wr_dest,
    output logic [15:0]      dc_wr_data,
    input  logic [15:0]      dc_rd_out,
    output logic             busy
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Request queue storage and control
    logic               r_q_we    [DEPTH];
    logic [15:0]        r_q_addr  [DEPTH];
    logic [15:0]        r_q_wdata [DEPTH];
    logic [TAG_W-1:0]   r_q_tag   [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    // In-flight load slot and 2-entry response buffer
    logic               r_inflight;
    logic [TAG_W-1:0]   r_inflight_tag;
    logic [15:0]        r_rb_data [2];
    logic [TAG_W-1:0]   r_rb_tag  [2];
    logic               r_rb_wr;
    logic               r_rb_rd;
    logic [1:0]         r_rb_occ;

    logic               w_push;
    logic               w_head_valid;
    logic               w_head_we;
    logic [15:0]        w_head_addr;
    logic [15:0]        w_head_wdata;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_rb_pop;
    logic [2:0]         w_used;
    logic               w_credit;
    logic               w_issue_st;
    logic               w_issue_ld;
    logic               w_pop;

    assign req_ready    = (r_count != c_FULL);
    assign w_push       = req_valid && req_ready;
    assign w_head_valid = (r_count != '0);
    assign w_head_we    = r_q_we[r_rd_ptr];
    assign w_head_addr  = r_q_addr[r_rd_ptr];
    assign w_head_wdata = r_q_wdata[r_rd_ptr];
    assign w_head_tag   = r_q_tag[r_rd_ptr];

    assign resp_valid   = (r_rb_occ != 2'd0);
    assign resp_data    = r_rb_data[r_rb_rd];
    assign resp_tag     = r_rb_tag[r_rb_rd];
    assign w_rb_pop     = resp_valid && resp_ready;

    // A load may only issue if its data is guaranteed a response-buffer slot
    assign w_used       = {1'b0, r_rb_occ} + {2'b00, r_inflight} - {2'b00, w_rb_pop};
    assign w_credit     = (w_used < 3'd2);
    assign w_issue_st   = w_head_valid && w_head_we;
    assign w_issue_ld   = w_head_valid && !w_head_we && w_credit;
    assign w_pop        = w_issue_st || w_issue_ld;

    assign dc_wr_en     = w_issue_st;
    assign dc_wr_dest   = w_issue_st ? w_head_addr  : 16'h0000;
    assign dc_wr_data   = w_issue_st ? w_head_wdata : 16'h0000;
    assign dc_rd_en     = w_issue_ld;
    assign dc_rd_dest   = w_issue_ld ? w_head_addr  : 16'h0000;

    assign busy         = w_head_valid || r_inflight || resp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_rb_wr    <= 1'b0;
            r_rb_rd    <= 1'b0;
            r_rb_occ   <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_inflight <= w_issue_ld;
            if (r_inflight) r_rb_wr <= ~r_rb_wr;
            if (w_rb_pop)   r_rb_rd <= ~r_rb_rd;
            case ({r_inflight, w_rb_pop})
                2'b10:   r_rb_occ <= r_rb_occ + 2'd1;
                2'b01:   r_rb_occ <= r_rb_occ - 2'd1;
                default: r_rb_occ <= r_rb_occ;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the counters above
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_we[r_wr_ptr]    <= req_we;
            r_q_addr[r_wr_ptr]  <= req_addr;
            r_q_wdata[r_wr_ptr] <= req_wdata;
            r_q_tag[r_wr_ptr]   <= req_tag;
        end
        if (w_issue_ld) r_inflight_tag <= w_head_tag;
        if (r_inflight) begin
            r_rb_data[r_rb_wr] <= dc_rd_out;
            r_rb_tag[r_rb_wr]  <= r_inflight_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural 1-cycle-latency cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_tag;
    logic        dc_rd_en;
    logic [15:0] dc_rd_dest;
    logic        dc_wr_en;
    logic [15:0] dc_wr_dest;
    logic [15:0] dc_wr_data;
    logic [15:0] dc_rd_out;
    logic        busy;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  tag;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
    } exp_t;

    req_t q_req[$];
    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   idx;

    load_store_unit #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag),
        .dc_rd_en(dc_rd_en), .dc_rd_dest(dc_rd_dest),
        .dc_wr_en(dc_wr_en), .dc_wr_dest(dc_wr_dest), .dc_wr_data(dc_wr_data),
        .dc_rd_out(dc_rd_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: preloaded with addr+0x100 while reset is held
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0100 + 16'(i);
        end else if (dc_wr_en) begin
            mem[dc_wr_dest[7:0]] <= dc_wr_data;
        end
        if (dc_rd_en) dc_rd_out <= mem[dc_rd_dest[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [3:0] tag);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_tag   = tag;
    endtask

    // Feed q_req in order and check every response against q_exp (resp_ready=1)
    task automatic run_queues(input int budget);
        int cyc;
        cyc = 0;
        while ((q_req.size() > 0 || q_exp.size() > 0) && cyc < budget) begin
            if (q_req.size() > 0) set_req(q_req[0].we, q_req[0].addr, q_req[0].wdata, q_req[0].tag);
            else req_valid = 1'b0;
            #1;
            if (resp_valid) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    chk("resp_data", 32'(resp_data), 32'(q_exp[0].data));
                    chk("resp_tag", 32'(resp_tag), 32'(q_exp[0].tag));
                    void'(q_exp.pop_front());
                end
            end
            if (req_valid && req_ready) void'(q_req.pop_front());
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        chk("seq_complete", 32'(q_req.size() + q_exp.size()), 32'd0);
        q_req.delete();
        q_exp.delete();
    endtask

    // Push loads with resp_ready=0 until the queue and response buffer fill
    task automatic fill_blocked(input logic [15:0] base);
        idx = 0;
        resp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 8) set_req(1'b0, base + 16'(idx), 16'h0, 4'(idx));
            else req_valid = 1'b0;
            #1;
            if (req_valid && req_ready) idx++;
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 16'h0;
        req_tag    = 4'h0;
        resp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(dc_rd_en), 32'd0);
        chk("rst_wr_en", 32'(dc_wr_en), 32'd0);
        rst = 1'b0;

        // Store then load back-to-back to the same address
        set_req(1'b1, 16'h0010, 16'hBEEF, 4'h0);
        tick();
        set_req(1'b0, 16'h0010, 16'h0, 4'h3);
        #1;
        chk("t1_wr_en", 32'(dc_wr_en), 32'd1);
        chk("t1_wr_dest", 32'(dc_wr_dest), 32'h0010);
        chk("t1_wr_data", 32'(dc_wr_data), 32'hBEEF);
        chk("t1_rd_en_c1", 32'(dc_rd_en), 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t1_rd_en", 32'(dc_rd_en), 32'd1);
        chk("t1_rd_dest", 32'(dc_rd_dest), 32'h0010);
        chk("t1_wr_en_c2", 32'(dc_wr_en), 32'd0);
        tick();
        #1;
        chk("t1_resp_c3", 32'(resp_valid), 32'd0);
        tick();
        #1;
        chk("t1_resp_c4", 32'(resp_valid), 32'd1);
        chk("t1_resp_data", 32'(resp_data), 32'hBEEF);
        chk("t1_resp_tag", 32'(resp_tag), 32'd3);
        tick();
        #1;
        chk("t1_resp_c5", 32'(resp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        tick();

        // Streaming loads: one response per cycle, cycles 3..10
        for (int c = 0; c < 12; c++) begin
            if (c < 8) set_req(1'b0, 16'(c), 16'h0, 4'(c));
            else req_valid = 1'b0;
            #1;
            chk("t2_resp_valid", 32'(resp_valid), (c >= 3 && c < 11) ? 32'd1 : 32'd0);
            if (c >= 3 && c < 11) begin
                chk("t2_resp_data", 32'(resp_data), 32'h0100 + 32'(c - 3));
                chk("t2_resp_tag", 32'(resp_tag), 32'(c - 3));
            end
            tick();
        end
        chk("t2_idle", 32'(busy), 32'd0);

        // Backpressure: two loads complete, four more fill the queue
        fill_blocked(16'h0000);
        #1;
        chk("t3_accepted", 32'(idx), 32'd6);
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        chk("t3_held_rd_en", 32'(dc_rd_en), 32'd0);
        chk("t3_resp_valid", 32'(resp_valid), 32'd1);
        chk("t3_resp_data", 32'(resp_data), 32'h0100);
        chk("t3_resp_tag", 32'(resp_tag), 32'd0);

        // Full queue with simultaneous pop: no accept this cycle
        resp_ready = 1'b1;
        #1;
        chk("t5_ready_on_pop", 32'(req_ready), 32'd0);
        chk("t5_rd_en", 32'(dc_rd_en), 32'd1);
        chk("t5_rd_dest", 32'(dc_rd_dest), 32'h0002);
        tick();
        chk("t5_ready_next", 32'(req_ready), 32'd1);
        q_req.push_back('{we: 1'b0, addr: 16'h0006, wdata: 16'h0, tag: 4'd6});
        q_req.push_back('{we: 1'b0, addr: 16'h0007, wdata: 16'h0, tag: 4'd7});
        for (int k = 1; k < 8; k++) q_exp.push_back('{data: 16'h0100 + 16'(k), tag: 4'(k)});
        run_queues(40);
        chk("t3_idle", 32'(busy), 32'd0);

        // Interleaved store/load to the top address
        q_req.push_back('{we: 1'b1, addr: 16'hFFFF, wdata: 16'h1234, tag: 4'd0});
        q_req.push_back('{we: 1'b0, addr: 16'hFFFF, wdata: 16'h0, tag: 4'd1});
        q_req.push_back('{we: 1'b1, addr: 16'hFFFF, wdata: 16'h5678, tag: 4'd0});
        q_req.push_back('{we: 1'b0, addr: 16'hFFFF, wdata: 16'h0, tag: 4'd2});
        q_exp.push_back('{data: 16'h1234, tag: 4'd1});
        q_exp.push_back('{data: 16'h5678, tag: 4'd2});
        run_queues(30);
        chk("t4_idle", 32'(busy), 32'd0);

        // Reset with three queued loads and one in flight
        fill_blocked(16'h0040);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("t6_pre_resp", 32'(resp_valid), 32'd1);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        chk("t6_rst_resp", 32'(resp_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rd_en", 32'(dc_rd_en), 32'd0);
        chk("t6_rst_wr_en", 32'(dc_wr_en), 32'd0);
        repeat (2) begin
            tick();
            chk("t6_rst_hold_resp", 32'(resp_valid), 32'd0);
        end
        rst        = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("t6_post_resp", 32'(resp_valid), 32'd0);
        chk("t6_post_busy", 32'(busy), 32'd0);
        set_req(1'b0, 16'h0020, 16'h0, 4'd5);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t6_lat_c1", 32'(resp_valid), 32'd0);
        tick();
        #1;
        chk("t6_lat_c2", 32'(resp_valid), 32'd0);
        tick();
        #1;
        chk("t6_lat_c3", 32'(resp_valid), 32'd1);
        chk("t6_resp_data", 32'(resp_data), 32'h0120);
        chk("t6_resp_tag", 32'(resp_tag), 32'd5);
        tick();
        #1;
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
